// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
//
// Purpose:
//   Collects COUNT accepted 32-bit sum words into one group total, modulo
//   2^32. A sticky flag records any unsigned carry out of bit 31 during the
//   group. The finished result is held until downstream consumes it.
//
// Handshake rules (both sides):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   A producer holding valid=1 keeps its data stable until the transfer.
//   Ready may depend combinationally on state and on clear, never on valid.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   Sum        in   [31:0] sum word from upstream
//   in_valid   in   Sum is valid this cycle
//   in_ready   out  block accepts Sum this cycle
//   clear      in   synchronous abort of the current group (highest priority)
//   Acc        out  [31:0] group total (running partial total while collecting)
//   Ovf        out  sticky carry-out flag for the group
//   out_valid  out  Acc/Ovf hold a completed group result
//   out_ready  in   downstream consumes the result this cycle
//   state_dbg  out  FSM state for observation: 0 = ACC, 1 = HOLD
// ---------------------------------------------------------------------------
module sum_accumulator #(
    parameter int unsigned COUNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Sum,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        clear,
    output logic [31:0] Acc,
    output logic        Ovf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        state_dbg
);

    // Counter is at least one bit wide so COUNT=1 still has a legal vector.
    localparam int unsigned CW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(COUNT - 1);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   acc_q, acc_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;

    logic          accept;
    logic [32:0]   sum_ext;

    // rst_n gates in_ready so nothing looks acceptable while reset is held.
    assign in_ready  = rst_n && (state_q == ST_ACC) && !clear;
    assign accept    = in_valid && in_ready;
    assign sum_ext   = {1'b0, acc_q} + {1'b0, Sum};

    assign Acc       = acc_q;
    assign Ovf       = ovf_q;
    assign out_valid = out_valid_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;

        if (clear) begin
            // Abort wins over everything, including a pending result.
            state_d     = ST_ACC;
            acc_d       = 32'd0;
            ovf_d       = 1'b0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        acc_d = sum_ext[31:0];
                        ovf_d = ovf_q | sum_ext[32];
                        if (cnt_q == CNT_LAST) begin
                            cnt_d       = '0;
                            state_d     = ST_HOLD;
                            out_valid_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Result stays frozen until consumed; the total is
                    // zeroed here so the next group starts from 0.
                    if (out_ready) begin
                        state_d     = ST_ACC;
                        acc_d       = 32'd0;
                        ovf_d       = 1'b0;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_ACC;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            acc_q       <= 32'd0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
